pti_fifo_target: RTL and testbench
==================================

# pti_fifo_target

Device-side responder for the 8-bit synchronous parallel FIFO interface, i.e. the pin-level behaviour of the FT-style USB FIFO bridge that the PTI host controller talks to. It owns two byte FIFOs:
- "up" FIFO: local logic → host, drained by host reads.
- "dn" FIFO: host → local logic, filled by host writes.

Used as a synthesizable board-to-board endpoint and as the bench model for PTI host verification.

## Interface
Parameters:
- DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries); counts are DEPTH_LOG2+1 bits.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  60 MHz interface clock, shared with the host side
- rst_ni  in  1  asynchronous active-low reset
- rxf_no  out  1  low = up FIFO has data for the host to read
- txe_no  out  1  low = dn FIFO can accept a host write
- rd_ni  in  1  host read strobe, active low
- wr_ni  in  1  host write strobe, active low
- oe_ni  in  1  host output enable, active low; target drives dat_io while low
- siwu_ni  in  1  send-immediate request, active low
- dat_io  inout  8  bidirectional data pins
- up_dat_i  in  8  byte to send to host
- up_wr_i  in  1  push up_dat_i into up FIFO
- up_full_o  out  1  up FIFO full
- dn_dat_o  out  8  head of dn FIFO (first-word-fall-through)
- dn_rd_i  in  1  pop dn FIFO
- dn_empty_o  out  1  dn FIFO empty
- ovr_o  out  1  sticky: host write attempted while txe_no high, or while oe_ni low
- udr_o  out  1  sticky: host read attempted while rxf_no high
- clr_i  in  1  synchronous clear of ovr_o/udr_o

## Operation
- dat_io = up FIFO head when oe_ni low (combinational enable); high-Z otherwise. When up FIFO empty, the last-driven value is held.
- Host read: on a rising edge with rd_ni=0 and rxf_no=0, pop up FIFO. With rd_ni=0 and rxf_no=1: no pop, set udr_o.
- Host write: on a rising edge with wr_ni=0, txe_no=0, oe_ni=1, push dat_io into dn FIFO. With wr_ni=0 and (txe_no=1 or oe_ni=0): byte dropped, set ovr_o.
- Local push: accepted iff up_wr_i=1 and up_full_o=0, evaluated at that edge; a same-edge host pop does not rescue a push into a full FIFO.
- Local pop: accepted iff dn_rd_i=1 and dn_empty_o=0; otherwise ignored, no flag.
- Push and pop on the same FIFO at the same edge both occur; the count is unchanged. Pointers wrap modulo 2^DEPTH_LOG2.
- rxf_no and txe_no are registered from next-state counts:
  - rxf_no <= (up_count_next == 0), subject to Configuration gating.
  - txe_no <= (dn_count_next == 2^DEPTH_LOG2).
- clr_i takes priority over a same-cycle set of ovr_o/udr_o.

## Timing
- Reset values: rxf_no=1, txe_no=1, up_full_o=0, dn_empty_o=1, ovr_o=0, udr_o=0, all counts/pointers 0, dat_io high-Z unless oe_ni low. txe_no falls on the first clock edge after reset release.
- Local push → rxf_no low: 1 cycle.
- Host pop of last byte → rxf_no high on the same edge (host sees it high on the next sample).
- A host write filling the dn FIFO sets txe_no high on that edge; local dn_rd_i → txe_no low: 1 cycle.
- dn_dat_o is valid in the cycle dn_empty_o is low. up_full_o/dn_empty_o update on the edge of the push/pop.
- Reset asserted mid-burst: FIFOs are flushed immediately, strobes are ignored and outputs return to reset values asynchronously.

## Configuration
- PTI_TGT_SIWU_EN defined:
  - rxf_no is held high until the up count reaches 2^(DEPTH_LOG2-1), or a flush flag is set.
  - siwu_ni sampled low sets the flush flag; the flag clears on the edge the up FIFO becomes empty.
  - While gated, host reads set udr_o.
- PTI_TGT_SIWU_EN undefined: rxf_no follows up-FIFO-empty only; siwu_ni is ignored.

## Test plan
- Reset, push 0x11,0x22,0x33 locally, host drives oe_ni=0 then rd_ni=0 for 3 cycles -> dat_io shows 0x11,0x22,0x33; rxf_no high after third pop; udr_o=0.
- Host writes 17 bytes 0x00..0x10 back-to-back (DEPTH_LOG2=4) -> 16 accepted, txe_no high after 16th, ovr_o=1, dn_dat_o=0x00; 16 dn_rd_i pops yield 0x00..0x0F.
- Simultaneous local push and host pop with one byte queued -> count stays 1, order preserved.
- Host wr_ni=0 with oe_ni=0 -> no push, ovr_o=1; clr_i with new error same cycle -> ovr_o=0.
- PTI_TGT_SIWU_EN: push 3 bytes -> rxf_no stays 1; pulse siwu_ni -> rxf_no=0 next cycle; drain 3 -> rxf_no=1, flush cleared; push 8 bytes -> rxf_no=0.
- Assert rst_ni mid host read burst -> rxf_no=1, txe_no=1, dn_empty_o=1 immediately; after release, txe_no=0 one edge later.

Source files
------------

// File: rtl/pti_fifo_target.sv
// rtl/pti_fifo_target.sv - device-side responder for the 8-bit synchronous parallel FIFO interface
//
// Owns two byte FIFOs of 2**DEPTH_LOG2 entries each:
//   up FIFO : local logic -> host, drained by host reads (rd_ni)
//   dn FIFO : host -> local logic, filled by host writes (wr_ni)
//
// Optional feature macro: PTI_TGT_SIWU_EN
//   defined   : rxf_no is gated until the up FIFO is half full or a
//               send-immediate (siwu_ni low) flush is pending
//   undefined : rxf_no follows up-FIFO-empty only, siwu_ni is ignored
//
// Ports:
//   clk_i        interface clock shared with the host
//   rst_ni       asynchronous active-low reset
//   rxf_no       low = up FIFO has data for the host
//   txe_no       low = dn FIFO can accept a host write
//   rd_ni        host read strobe, active low
//   wr_ni        host write strobe, active low
//   oe_ni        host output enable, active low (target drives dat_io)
//   siwu_ni      send-immediate request, active low
//   dat_io       bidirectional data pins
//   up_dat_i     byte to push into the up FIFO
//   up_wr_i      push strobe for the up FIFO
//   up_full_o    up FIFO full
//   dn_dat_o     head of dn FIFO (first-word-fall-through)
//   dn_rd_i      pop strobe for the dn FIFO
//   dn_empty_o   dn FIFO empty
//   ovr_o        sticky: host write while txe_no high or oe_ni low
//   udr_o        sticky: host read while rxf_no high
//   clr_i        synchronous clear of ovr_o/udr_o

module pti_fifo_target #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic       rxf_no,
    output logic       txe_no,
    input  logic       rd_ni,
    input  logic       wr_ni,
    input  logic       oe_ni,
    input  logic       siwu_ni,
    inout  wire  [7:0] dat_io,
    input  logic [7:0] up_dat_i,
    input  logic       up_wr_i,
    output logic       up_full_o,
    output logic [7:0] dn_dat_o,
    input  logic       dn_rd_i,
    output logic       dn_empty_o,
    output logic       ovr_o,
    output logic       udr_o,
    input  logic       clr_i
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   ONE_CNT  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] ONE_PTR  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    // Storage and pointers
    logic [7:0]            up_mem [DEPTH];
    logic [7:0]            dn_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] up_wptr, up_rptr;
    logic [DEPTH_LOG2-1:0] dn_wptr, dn_rptr;
    logic [DEPTH_LOG2:0]   up_count, dn_count;
    logic [DEPTH_LOG2:0]   up_count_next, dn_count_next;

    // Last byte presented on the pins, re-driven when the up FIFO runs dry
    logic [7:0] hold_q;
    logic [7:0] up_head;
    logic [7:0] pin_dat;

    // Accepted transfers at this edge
    logic host_pop, host_push, loc_push, loc_pop;
    logic udr_set, ovr_set;
    logic rxf_next, txe_next;

    // rxf_no/txe_no are registered, so they already encode "count==0" /
    // "count==full" for the current cycle; qualifying host strobes with
    // them guarantees a host access never underflows or overflows.
    assign host_pop  = ~rd_ni & ~rxf_no;
    assign udr_set   = ~rd_ni &  rxf_no;
    assign host_push = ~wr_ni & ~txe_no & oe_ni;
    assign ovr_set   = ~wr_ni & (txe_no | ~oe_ni);

    // Local push is judged on the pre-edge full flag only, so a host pop
    // at the same edge cannot make room for it.
    assign loc_push  = up_wr_i & ~up_full_o;
    assign loc_pop   = dn_rd_i & ~dn_empty_o;

    assign up_full_o  = (up_count == FULL_CNT);
    assign dn_empty_o = (dn_count == '0);

    assign up_head  = up_mem[up_rptr];
    assign dn_dat_o = dn_mem[dn_rptr];
    assign pin_dat  = (up_count == '0) ? hold_q : up_head;
    assign dat_io   = oe_ni ? 8'bz : pin_dat;

    always_comb begin
        up_count_next = up_count;
        case ({loc_push, host_pop})
            2'b10:   up_count_next = up_count + ONE_CNT;
            2'b01:   up_count_next = up_count - ONE_CNT;
            default: up_count_next = up_count;
        endcase
    end

    always_comb begin
        dn_count_next = dn_count;
        case ({host_push, loc_pop})
            2'b10:   dn_count_next = dn_count + ONE_CNT;
            2'b01:   dn_count_next = dn_count - ONE_CNT;
            default: dn_count_next = dn_count;
        endcase
    end

    assign txe_next = (dn_count_next == FULL_CNT);

`ifdef PTI_TGT_SIWU_EN
    localparam logic [DEPTH_LOG2:0] HALF_CNT = {2'b01, {(DEPTH_LOG2-1){1'b0}}};

    logic flush_q;
    logic flush_next;

    // The flush request survives until the up FIFO drains completely.
    always_comb begin
        flush_next = flush_q | ~siwu_ni;
        if (up_count_next == '0) begin
            flush_next = 1'b0;
        end
    end

    assign rxf_next = (up_count_next == '0) |
                      ~((up_count_next >= HALF_CNT) | flush_next);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flush_q <= 1'b0;
        end else begin
            flush_q <= flush_next;
        end
    end
`else
    logic unused_siwu;
    assign unused_siwu = siwu_ni;
    assign rxf_next    = (up_count_next == '0);
`endif

    // Memories carry no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (loc_push) begin
            up_mem[up_wptr] <= up_dat_i;
        end
        if (host_push) begin
            dn_mem[dn_wptr] <= dat_io;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            up_wptr  <= '0;
            up_rptr  <= '0;
            up_count <= '0;
            dn_wptr  <= '0;
            dn_rptr  <= '0;
            dn_count <= '0;
            hold_q   <= 8'h00;
            rxf_no   <= 1'b1;
            txe_no   <= 1'b1;
            ovr_o    <= 1'b0;
            udr_o    <= 1'b0;
        end else begin
            if (loc_push) begin
                up_wptr <= up_wptr + ONE_PTR;
            end
            if (host_pop) begin
                up_rptr <= up_rptr + ONE_PTR;
            end
            if (host_push) begin
                dn_wptr <= dn_wptr + ONE_PTR;
            end
            if (loc_pop) begin
                dn_rptr <= dn_rptr + ONE_PTR;
            end
            up_count <= up_count_next;
            dn_count <= dn_count_next;

            if (!oe_ni && (up_count != '0)) begin
                hold_q <= up_head;
            end

            rxf_no <= rxf_next;
            txe_no <= txe_next;

            // Clear wins over a same-cycle error.
            ovr_o <= clr_i ? 1'b0 : (ovr_o | ovr_set);
            udr_o <= clr_i ? 1'b0 : (udr_o | udr_set);
        end
    end

endmodule

// File: tb/tb_pti_fifo_target.sv
// tb/tb_pti_fifo_target.sv - self-checking bench for pti_fifo_target
module tb_pti_fifo_target;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rd_n   = 1'b1;
    logic       wr_n   = 1'b1;
    logic       oe_n   = 1'b1;
    logic       siwu_n = 1'b1;
    logic       up_wr  = 1'b0;
    logic       dn_rd  = 1'b0;
    logic       clr    = 1'b0;
    logic [7:0] up_dat = 8'h00;
    logic [7:0] tb_dat = 8'h00;
    wire  [7:0] dat_io;

    logic       rxf_n, txe_n, up_full, dn_empty, ovr, udr;
    logic [7:0] dn_dat;

    int n_chk  = 0;
    int n_pass = 0;

    assign dat_io = oe_n ? tb_dat : 8'bz;

    always #5 clk = ~clk;

    pti_fifo_target #(.DEPTH_LOG2(4)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rxf_no     (rxf_n),
        .txe_no     (txe_n),
        .rd_ni      (rd_n),
        .wr_ni      (wr_n),
        .oe_ni      (oe_n),
        .siwu_ni    (siwu_n),
        .dat_io     (dat_io),
        .up_dat_i   (up_dat),
        .up_wr_i    (up_wr),
        .up_full_o  (up_full),
        .dn_dat_o   (dn_dat),
        .dn_rd_i    (dn_rd),
        .dn_empty_o (dn_empty),
        .ovr_o      (ovr),
        .udr_o      (udr),
        .clr_i      (clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Behavioural model: two byte queues plus the status flags
    logic [7:0] up_q[$];
    logic [7:0] dn_q[$];
    logic       m_rxf_n = 1'b1;
    logic       m_txe_n = 1'b1;
    logic       m_ovr   = 1'b0;
    logic       m_udr   = 1'b0;
    logic       m_flush = 1'b0;
    logic [7:0] m_hold  = 8'h00;
    logic       h_rd, h_wr, l_push, l_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q.delete();
            dn_q.delete();
            m_rxf_n = 1'b1;
            m_txe_n = 1'b1;
            m_ovr   = 1'b0;
            m_udr   = 1'b0;
            m_flush = 1'b0;
            m_hold  = 8'h00;
        end else begin
            h_rd   = !rd_n && !m_rxf_n;
            h_wr   = !wr_n && !m_txe_n && oe_n;
            l_push = up_wr && (up_q.size() < 16);
            l_pop  = dn_rd && (dn_q.size() > 0);
            m_udr  = !clr && (m_udr || (!rd_n && m_rxf_n));
            m_ovr  = !clr && (m_ovr || (!wr_n && (m_txe_n || !oe_n)));
            if (!oe_n && up_q.size() > 0) m_hold = up_q[0];
            if (h_rd) void'(up_q.pop_front());
            if (l_push) up_q.push_back(up_dat);
            if (h_wr) dn_q.push_back(tb_dat);
            if (l_pop) void'(dn_q.pop_front());
            m_txe_n = (dn_q.size() == 16);
`ifdef PTI_TGT_SIWU_EN
            m_flush = (up_q.size() == 0) ? 1'b0 : (m_flush || !siwu_n);
            m_rxf_n = (up_q.size() == 0) || !((up_q.size() >= 8) || m_flush);
`else
            m_rxf_n = (up_q.size() == 0);
`endif
        end
    end

    always @(negedge clk) begin
        chk("rxf_no", rxf_n, m_rxf_n);
        chk("txe_no", txe_n, m_txe_n);
        chk("up_full_o", up_full, up_q.size() == 16);
        chk("dn_empty_o", dn_empty, dn_q.size() == 0);
        chk("ovr_o", ovr, m_ovr);
        chk("udr_o", udr, m_udr);
        if (dn_q.size() > 0) chk("dn_dat_o", dn_dat, dn_q[0]);
        if (!oe_n) chk("dat_io", dat_io, (up_q.size() > 0) ? up_q[0] : m_hold);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [7:0] exp3 [3];

    initial begin
        exp3 = '{8'h11, 8'h22, 8'h33};

        // Reset state
        repeat (2) tick();
        #1;
        chk("rst_rxf", rxf_n, 1'b1);
        chk("rst_txe", txe_n, 1'b1);
        chk("rst_full", up_full, 1'b0);
        chk("rst_empty", dn_empty, 1'b1);
        chk("rst_ovr", ovr, 1'b0);
        chk("rst_udr", udr, 1'b0);
        rst_n = 1'b1;
        tick();
        #1 chk("txe_after_rst", txe_n, 1'b0);

`ifndef PTI_TGT_SIWU_EN
        // Local push of three bytes, host reads them back
        up_wr = 1'b1;
        up_dat = 8'h11; tick();
        up_dat = 8'h22; tick();
        up_dat = 8'h33; tick();
        up_wr = 1'b0;
        #1 chk("rxf_with_data", rxf_n, 1'b0);
        oe_n = 1'b0;
        rd_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("rd_data", dat_io, exp3[i]);
            tick();
        end
        rd_n = 1'b1;
        #1;
        chk("rxf_after_drain", rxf_n, 1'b1);
        chk("udr_after_drain", udr, 1'b0);
        chk("dat_hold", dat_io, 8'h33);
        oe_n = 1'b1;
        tick();

        // Host writes 17 bytes: 16 accepted, 17th overruns
        wr_n = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tb_dat = 8'(i);
            tick();
        end
        wr_n = 1'b1;
        #1;
        chk("txe_full", txe_n, 1'b1);
        chk("ovr_full", ovr, 1'b1);
        chk("dn_head", dn_dat, 8'h00);
        clr = 1'b1; tick(); clr = 1'b0;
        #1 chk("ovr_cleared", ovr, 1'b0);
        dn_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1 chk("dn_pop_data", dn_dat, 8'(i));
            tick();
        end
        dn_rd = 1'b0;
        #1;
        chk("dn_drained", dn_empty, 1'b1);
        chk("txe_drained", txe_n, 1'b0);

        // Simultaneous local push and host pop with one byte queued
        up_wr = 1'b1; up_dat = 8'hA5; tick();
        up_dat = 8'h5A; oe_n = 1'b0; rd_n = 1'b0;
        #1 chk("sim_head0", dat_io, 8'hA5);
        tick();
        up_wr = 1'b0; rd_n = 1'b1;
        #1;
        chk("sim_head1", dat_io, 8'h5A);
        chk("sim_rxf", rxf_n, 1'b0);
        rd_n = 1'b0; tick(); rd_n = 1'b1; oe_n = 1'b1;
        #1 chk("sim_rxf_end", rxf_n, 1'b1);

        // Fill up FIFO; a push into full is not rescued by a same-edge pop
        up_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            up_dat = 8'h40 + 8'(i);
            tick();
        end
        #1 chk("up_full", up_full, 1'b1);
        up_dat = 8'hEE; oe_n = 1'b0; rd_n = 1'b0;
        tick();
        up_wr = 1'b0;
        #1;
        chk("full_no_rescue", up_full, 1'b0);
        chk("full_head", dat_io, 8'h41);
        repeat (15) tick();
        rd_n = 1'b1; oe_n = 1'b1;
        #1;
        chk("full_drained", rxf_n, 1'b1);
        chk("full_udr", udr, 1'b0);

        // Host write with oe_ni low, then clear beating a new error
        oe_n = 1'b0; wr_n = 1'b0; tick();
        #1;
        chk("ovr_oe", ovr, 1'b1);
        chk("ovr_oe_nopush", dn_empty, 1'b1);
        clr = 1'b1; tick(); clr = 1'b0; wr_n = 1'b1; oe_n = 1'b1;
        #1 chk("clr_priority", ovr, 1'b0);
        rd_n = 1'b0; tick(); rd_n = 1'b1;
        #1 chk("udr_set", udr, 1'b1);
        clr = 1'b1; tick(); clr = 1'b0;
        #1 chk("udr_clr", udr, 1'b0);
`else
        // Send-immediate gating
        up_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up_dat = 8'h60 + 8'(i);
            tick();
        end
        up_wr = 1'b0;
        #1 chk("siwu_gated", rxf_n, 1'b1);
        siwu_n = 1'b0; tick(); siwu_n = 1'b1;
        #1 chk("siwu_open", rxf_n, 1'b0);
        oe_n = 1'b0; rd_n = 1'b0;
        repeat (3) tick();
        rd_n = 1'b1; oe_n = 1'b1;
        #1 chk("siwu_drained", rxf_n, 1'b1);
        up_wr = 1'b1;
        for (int i = 0; i < 7; i++) begin
            up_dat = 8'h70 + 8'(i);
            tick();
        end
        #1 chk("siwu_seven", rxf_n, 1'b1);
        up_dat = 8'h77; tick(); up_wr = 1'b0;
        #1 chk("siwu_half", rxf_n, 1'b0);
        oe_n = 1'b0; rd_n = 1'b0;
        repeat (8) tick();
        rd_n = 1'b1; oe_n = 1'b1;
        #1 chk("siwu_end", rxf_n, 1'b1);
`endif

        // Reset asserted during a host read burst
        up_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_dat = 8'hC0 + 8'(i);
            tick();
        end
        up_wr = 1'b0;
        wr_n = 1'b0; tb_dat = 8'h77; tick(); tick(); wr_n = 1'b1;
`ifdef PTI_TGT_SIWU_EN
        siwu_n = 1'b0; tick(); siwu_n = 1'b1;
`endif
        oe_n = 1'b0; rd_n = 1'b0; tick();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_rxf", rxf_n, 1'b1);
        chk("mid_rst_txe", txe_n, 1'b1);
        chk("mid_rst_empty", dn_empty, 1'b1);
        chk("mid_rst_full", up_full, 1'b0);
        tick();
        rst_n = 1'b1; rd_n = 1'b1; oe_n = 1'b1;
        #1 chk("rel_txe_high", txe_n, 1'b1);
        tick();
        #1 chk("rel_txe_low", txe_n, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
